bcd_rtc_counter: RTL and testbench

BCD_RTC_COUNTER -- requirements
Module: bcd_rtc_counter

---
 rtl/bcd_rtc_counter.sv | 148 ++++++++++++++
 tb/tb_bcd_rtc_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_rtc_counter.sv
// rtl/bcd_rtc_counter.sv - BCD real-time clock counter with prescaler, set mode and optional alarm
//
// Purpose: divides clk by CLK_DIV into one-second ticks and keeps HH:MM:SS in
// packed BCD, in 24-hour (H24=1) or 12-hour with pm flag (H24=0) form.
// With run=0 the prescaler is held at 0 and inc steps the field picked by
// set_sel, with wrap and no carry.
// Optional feature: define BCD_RTC_ALARM_EN to build the HH:MM (+pm) alarm.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   run        1 = count time, 0 = set mode
//   set_sel    field for set mode: 0 sec, 1 min, 2 hour, 3 none
//   inc        increment request for the selected field (set mode only)
//   alarm_wr   load alarm_bcd / alarm_pm into the alarm register
//   alarm_bcd  alarm {HH,MM} packed BCD
//   alarm_pm   alarm pm flag (12-hour mode only)
//   time_bcd   {HH,MM,SS} packed BCD
//   pm         pm flag, 0 in 24-hour mode
//   sec_pulse  one-cycle strobe with each tick-advanced time_bcd
//   alarm_hit  one-cycle strobe when a tick reaches HH:MM:00 equal to the alarm

module bcd_rtc_counter #(
   parameter int unsigned CLK_DIV = 100_000_000,
   parameter bit          H24     = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic [1:0]  set_sel,
   input  logic        inc,
   input  logic        alarm_wr,
   input  logic [15:0] alarm_bcd,
   input  logic        alarm_pm,
   output logic [23:0] time_bcd,
   output logic        pm,
   output logic        sec_pulse,
   output logic        alarm_hit
);

   localparam logic [31:0] PRESC_LAST = 32'(CLK_DIV - 1);

   logic [31:0] presc;
   logic        tick;
   logic [7:0]  sec, min, hr;
   logic [7:0]  sec_n, min_n, hr_n;
   logic        pm_n;

   // 00..59 BCD increment with wrap
   function automatic logic [7:0] inc_sixty(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         if (v[7:4] == 4'd5) return 8'h00;
         return {v[7:4] + 4'd1, 4'd0};
      end
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // 00..23 or 01..12 BCD increment with wrap
   function automatic logic [7:0] inc_hour(input logic [7:0] v);
      if (H24) begin
         if (v == 8'h23) return 8'h00;
      end else begin
         if (v == 8'h12) return 8'h01;
      end
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign tick     = run && (presc == PRESC_LAST);
   assign time_bcd = {hr, min, sec};

   // Next time value: a tick ripples carries through all fields in one cycle,
   // a set-mode edit touches only the selected field.
   always_comb begin
      sec_n = sec;
      min_n = min;
      hr_n  = hr;
      pm_n  = pm;
      if (tick) begin
         sec_n = inc_sixty(sec);
         if (sec == 8'h59) begin
            min_n = inc_sixty(min);
            if (min == 8'h59) begin
               hr_n = inc_hour(hr);
               if (!H24 && hr == 8'h11) pm_n = ~pm;
            end
         end
      end else if (!run && inc) begin
         case (set_sel)
            2'd0: sec_n = inc_sixty(sec);
            2'd1: min_n = inc_sixty(min);
            2'd2: begin
               hr_n = inc_hour(hr);
               if (!H24 && hr == 8'h11) pm_n = ~pm;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc     <= '0;
         sec       <= 8'h00;
         min       <= 8'h00;
         hr        <= H24 ? 8'h00 : 8'h12;
         pm        <= 1'b0;
         sec_pulse <= 1'b0;
      end else begin
         presc     <= (run && !tick) ? presc + 32'd1 : 32'd0;
         sec       <= sec_n;
         min       <= min_n;
         hr        <= hr_n;
         pm        <= pm_n;
         sec_pulse <= tick;
      end
   end

`ifdef BCD_RTC_ALARM_EN
   logic [15:0] alarm_reg;
   logic        alarm_pm_reg;
   logic        alarm_match;

   // Compared against the stored value, so a same-cycle alarm_wr takes
   // effect only from the next tick on.
   assign alarm_match = ({hr_n, min_n} == alarm_reg) && (sec_n == 8'h00) &&
                        (H24 || (pm_n == alarm_pm_reg));

   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_reg    <= 16'h0000;
         alarm_pm_reg <= 1'b0;
         alarm_hit    <= 1'b0;
      end else begin
         alarm_hit <= tick && alarm_match;
         if (alarm_wr) begin
            alarm_reg    <= alarm_bcd;
            alarm_pm_reg <= alarm_pm;
         end
      end
   end
`else
   logic unused_alarm;
   assign unused_alarm = ^{alarm_wr, alarm_bcd, alarm_pm};
   assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_rtc_counter.sv
// tb/tb_bcd_rtc_counter.sv - randomized self-checking bench for bcd_rtc_counter (24h and 12h instances)

module tb_bcd_rtc_counter;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [1:0]  set_sel;
   logic        inc;
   logic        alarm_wr;
   logic [15:0] alarm_bcd;
   logic        alarm_pm;

   logic [23:0] time24, time12;
   logic        pm24, pm12, pulse24, pulse12, hit24, hit12;

   int chk_cnt  = 0;
   int fail_cnt = 0;
   bit chk_en   = 1'b0;

   // reference model: time as seconds since midnight
   int   m_t, m_cnt;
   bit   m_tick, m_pulse, m_hit24, m_hit12;
   logic [15:0] m_alarm;
   bit   m_apm;

   always #5 clk = ~clk;

   bcd_rtc_counter #(.CLK_DIV(DIV), .H24(1'b1)) u_dut24 (
      .clk(clk), .rst(rst), .run(run), .set_sel(set_sel), .inc(inc),
      .alarm_wr(alarm_wr), .alarm_bcd(alarm_bcd), .alarm_pm(alarm_pm),
      .time_bcd(time24), .pm(pm24), .sec_pulse(pulse24), .alarm_hit(hit24));

   bcd_rtc_counter #(.CLK_DIV(DIV), .H24(1'b0)) u_dut12 (
      .clk(clk), .rst(rst), .run(run), .set_sel(set_sel), .inc(inc),
      .alarm_wr(alarm_wr), .alarm_bcd(alarm_bcd), .alarm_pm(alarm_pm),
      .time_bcd(time12), .pm(pm12), .sec_pulse(pulse12), .alarm_hit(hit12));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [23:0] fmt24(input int t);
      return {to_bcd(t / 3600), to_bcd((t / 60) % 60), to_bcd(t % 60)};
   endfunction

   function automatic logic [23:0] fmt12(input int t);
      int h;
      h = (t / 3600) % 12;
      if (h == 0) h = 12;
      return {to_bcd(h), to_bcd((t / 60) % 60), to_bcd(t % 60)};
   endfunction

   always @(posedge clk) begin
      logic [23:0] f24, f12;
      if (rst) begin
         m_t = 0; m_cnt = 0; m_pulse = 0; m_hit24 = 0; m_hit12 = 0;
         m_alarm = 16'h0000; m_apm = 0;
      end else begin
         m_tick  = run && (m_cnt == DIV - 1);
         m_cnt   = (run && !m_tick) ? m_cnt + 1 : 0;
         m_pulse = m_tick;
         m_hit24 = 0;
         m_hit12 = 0;
         if (m_tick) begin
            m_t = (m_t + 1) % 86400;
`ifdef BCD_RTC_ALARM_EN
            f24 = fmt24(m_t);
            f12 = fmt12(m_t);
            m_hit24 = (m_t % 60 == 0) && (f24[23:8] == m_alarm);
            m_hit12 = (m_t % 60 == 0) && (f12[23:8] == m_alarm) && ((m_t >= 43200) == m_apm);
`endif
         end else if (!run && inc) begin
            case (set_sel)
               2'd0: m_t = m_t - (m_t % 60) + ((m_t % 60) + 1) % 60;
               2'd1: m_t = m_t - ((m_t / 60) % 60) * 60 + (((m_t / 60) % 60 + 1) % 60) * 60;
               2'd2: m_t = (m_t + 3600) % 86400;
               default: ;
            endcase
         end
         if (alarm_wr) begin
            m_alarm = alarm_bcd;
            m_apm   = alarm_pm;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("time24", 32'(time24), 32'(fmt24(m_t)));
         check("pm24", 32'(pm24), 32'(0));
         check("pulse24", 32'(pulse24), 32'(m_pulse));
         check("hit24", 32'(hit24), 32'(m_hit24));
         check("time12", 32'(time12), 32'(fmt12(m_t)));
         check("pm12", 32'(pm12), 32'(m_t >= 43200));
         check("pulse12", 32'(pulse12), 32'(m_pulse));
         check("hit12", 32'(hit12), 32'(m_hit12));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic hold_inc(input logic [1:0] sel, input int n);
      if (n > 0) begin
         set_sel = sel;
         inc     = 1'b1;
         step(n);
         inc     = 1'b0;
      end
   endtask

   task automatic set_time(input int h, input int m, input int s);
      run = 1'b0;
      step(1);
      hold_inc(2'd0, (s - m_t % 60 + 60) % 60);
      hold_inc(2'd1, (m - (m_t / 60) % 60 + 60) % 60);
      hold_inc(2'd2, (h - m_t / 3600 + 24) % 24);
   endtask

   task automatic wait_presc_last();
      bit found;
      found = 0;
      for (int i = 0; i < 4 * DIV; i++) begin
         if (run && m_cnt == DIV - 1) begin
            found = 1;
            break;
         end
         step(1);
      end
      if (!found) check("presc_wait", 32'(0), 32'(1));
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; set_sel = 2'd3; inc = 1'b0;
      alarm_wr = 1'b0; alarm_bcd = 16'h0000; alarm_pm = 1'b0;
      step(1);
      chk_en = 1'b1;
      step(1);
      rst = 1'b0;

      // free run from reset
      run = 1'b1;
      step(10 * DIV + 2);

      // day wrap, 11->12 with pm toggle, 12->01 without
      set_time(23, 59, 59); run = 1'b1; step(DIV + 2);
      set_time(11, 59, 59); run = 1'b1; step(DIV + 2);
      set_time(12, 59, 59); run = 1'b1; step(DIV + 2);
      set_time(0, 59, 59);  run = 1'b1; step(DIV + 2);

      // minute edit without carry, inc ignored while running
      set_time(0, 59, 30);
      set_sel = 2'd1; inc = 1'b1; step(1); inc = 1'b0; step(2);
      set_sel = 2'd3; inc = 1'b1; step(2); inc = 1'b0;
      run = 1'b1; set_sel = 2'd1; inc = 1'b1; step(3); inc = 1'b0; step(DIV);

      // alarm on tick, none through set-mode edits
      run = 1'b0;
      alarm_bcd = 16'h0701; alarm_pm = 1'b0; alarm_wr = 1'b1; step(1); alarm_wr = 1'b0;
      set_time(7, 0, 59); run = 1'b1; step(2 * DIV + 2);
      set_time(7, 0, 0); set_time(7, 1, 0); step(2);

      // alarm_wr in the matching tick cycle compares the old value
      set_time(7, 0, 59); run = 1'b1;
      wait_presc_last();
      alarm_bcd = 16'h1234; alarm_wr = 1'b1; step(1); alarm_wr = 1'b0; step(DIV + 2);

      // reset in the tick cycle
      wait_presc_last();
      rst = 1'b1; step(1); rst = 1'b0; step(3 * DIV + 2);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) run = ~run;
         inc     = ($urandom_range(0, 3) == 0);
         set_sel = 2'($urandom_range(0, 3));
         alarm_wr = ($urandom_range(0, 39) == 0);
         if (alarm_wr) begin
            logic [23:0] f;
            f = ($urandom_range(0, 1) == 0) ? fmt24((m_t + 60) % 86400) : fmt12((m_t + 60) % 86400);
            alarm_bcd = f[23:8];
            alarm_pm  = ((m_t + 60) % 86400) >= 43200;
         end
         rst = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 299) == 0) begin
            inc = 1'b0; rst = 1'b0; alarm_wr = 1'b0;
            set_time(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)), 59);
            run = 1'b1;
         end
         step(1);
      end
      rst = 1'b0; inc = 1'b0; alarm_wr = 1'b0;
      step(2);
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
      $finish;
   end

endmodule
